// File: rtl/tick_timer.sv
// tick_timer: prescaled elapsed-time counter.
// A prescaler divides clk by DIV = CLK_HZ/TICK_HZ. Each prescaler rollover
// produces a tick that counts a CNT_W-bit register up or down between 0 and
// MAX_COUNT, either wrapping or saturating at the limits.
// Optional alarm compare is built when TICK_TIMER_ALARM_EN is defined.
module tick_timer #(
    parameter int               CLK_HZ    = 100000000,
    parameter int               TICK_HZ   = 1,
    parameter int               CNT_W     = 4,
    parameter logic [CNT_W-1:0] MAX_COUNT = {CNT_W{1'b1}},
    parameter bit               SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dir,
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic             tc
`ifdef TICK_TIMER_ALARM_EN
    ,
    input  logic [CNT_W-1:0] alarm_val,
    output logic             alarm
`endif
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    // Reject configurations that cannot produce a sensible tick or count.
    generate
        if (DIV < 2) begin : g_bad_div
            $error("tick_timer: CLK_HZ/TICK_HZ must be at least 2");
        end
        if (CNT_W < 1 || CNT_W > 32) begin : g_bad_width
            $error("tick_timer: CNT_W must be in 1..32");
        end
    endgenerate

    logic [PW-1:0]    pre_reg;
    logic [CNT_W-1:0] count_reg;
    logic             tick_reg;
    logic             tc_reg;

    logic             tick_now;
    logic             at_limit;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] load_clamped;

    // Tick detection, limit detection and the next count value for a tick.
    always_comb begin
        tick_now     = en && (pre_reg == PRE_LAST);
        at_limit     = dir ? (count_reg == MAX_COUNT) : (count_reg == '0);
        load_clamped = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;
        count_next   = count_reg;
        if (dir) begin
            if (at_limit)
                count_next = SATURATE ? MAX_COUNT : '0;
            else
                count_next = count_reg + 1'b1;
        end else begin
            if (at_limit)
                count_next = SATURATE ? '0 : MAX_COUNT;
            else
                count_next = count_reg - 1'b1;
        end
    end

    // Prescaler, count and strobes; clear and load discard a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_reg   <= '0;
            count_reg <= '0;
            tick_reg  <= 1'b0;
            tc_reg    <= 1'b0;
        end else if (clear) begin
            pre_reg   <= '0;
            count_reg <= '0;
            tick_reg  <= 1'b0;
            tc_reg    <= 1'b0;
        end else if (load) begin
            pre_reg   <= '0;
            count_reg <= load_clamped;
            tick_reg  <= 1'b0;
            tc_reg    <= 1'b0;
        end else begin
            tick_reg <= tick_now;
            tc_reg   <= tick_now && at_limit;
            if (en)
                pre_reg <= tick_now ? '0 : pre_reg + 1'b1;
            if (tick_now)
                count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign tick  = tick_reg;
    assign tc    = tc_reg;

`ifdef TICK_TIMER_ALARM_EN
    logic alarm_reg;

    // Sticky alarm: set only when a tick moves the count onto alarm_val.
    always_ff @(posedge clk) begin
        if (rst || clear || load)
            alarm_reg <= 1'b0;
        else if (tick_now && (count_next == alarm_val))
            alarm_reg <= 1'b1;
    end

    assign alarm = alarm_reg;
`endif

endmodule
